warp_instr_decoder: RTL and testbench
=====================================

// Module: warp_instr_decoder
// PURPOSE
// Parametrised, handshaked instruction decoder shared by NUM_WARPS warps; successor of the single-warp decode stage.
// Accepts one (instruction, warp id) per cycle, decodes it and queues the bundle in a FIFO_DEPTH-entry output buffer.
// Tracks per-warp halt state and flags illegal encodings instead of aborting simulation; sits between fetch and issue.
// PARAMETERS
// NUM_WARPS   4   warps sharing the decoder; WID_W = $clog2(NUM_WARPS), min 1
// FIFO_DEPTH  2   output buffer entries (>=1)
// CNT_WIDTH   16  width of decode/illegal counters
// IS_SCALAR   0   1: scalar-core instance, out_scalar_instruction=1 on every non-halt entry
// PORTS
// clk                     in   1          clock
// reset                   in   1          asynchronous, active-low reset
// in_valid                in   1          instruction offered
// in_ready                out  1          decoder can accept
// in_instruction          in   32         instruction_t
// in_warp_id              in   WID_W      issuing warp
// warp_restart            in   NUM_WARPS  per-warp pulse clearing halted state
// out_valid               out  1          head entry valid
// out_ready               in   1          consumer takes head
// out_warp_id             out  WID_W      warp of head entry
// out_reg_write_enable / out_mem_write_enable / out_mem_read_enable / out_branch / out_halt / out_illegal / out_scalar_instruction  out 1 each
// out_reg_input_mux       out  reg_input_mux_t    ALU_OUT/LSU_OUT/IMMEDIATE
// out_immediate           out  `DATA_WIDTH        sign/zero-extended immediate
// out_rd/out_rs1/out_rs2  out  5 each             register addresses
// out_alu_instruction     out  alu_instruction_t  ALU op
// warp_halted             out  NUM_WARPS  per-warp halted flags
// decode_count            out  CNT_WIDTH  entries pushed, wraps
// illegal_count           out  CNT_WIDTH  illegal entries pushed, saturates at all-ones
// BEHAVIOUR
// - Reset (reset=0, async): FIFO empty, out_valid=0, all out_* = 0 except mux=ALU_OUT, alu=ADDI; warp_halted=0; counters=0.
// - in_ready = (occupancy < FIFO_DEPTH); no combinational path from out_ready. Accept = in_valid & in_ready.
// - Latency 1: accepted at edge N -> visible at head after edge N if FIFO was empty. Pop = out_valid & out_ready.
//   Push+pop same edge: occupancy unchanged; order strictly FIFO. out_* are head-entry fields, held stable while out_ready=0.
// - Fields: opcode[31:29], funct3[14:12], funct4[13:10], rd[4:0], rs1[9:5], rs2[18:14].
// - Defaults per entry: enables 0, mux ALU_OUT, imm 0, addrs 0, alu ADDI, halt 0, illegal 0.
// - `OPCODE_HALT: out_halt=1; sets warp_halted[w] at accept edge.
// - `OPCODE_J f3=000: JAL, imm=sext({i[28:13],i[9:0],2'b00}). f3=001: BEQ, branch=1, rs1, rs2,
//   imm=sext({i[28:19],i[13],i[4:0],2'b00}).
// - `OPCODE_R: rd,rs1,rs2, wr=1; f4 0000 ADD,0001 SUB,0010 MUL,0011 DIV,0100 SLT,0110 SEQ,0111 SNEZ,1000 MIN,1001 ABS.
// - `OPCODE_I: rd,rs1, wr=1, imm=sext(i[27:14]); f4 0000 ADDI,0010 MULI,0011 DIVI,1010 SLLI.
// - `OPCODE_F: rd,rs1, wr=1; f4 0000..1010 = FADD,FSUB,FMUL,FDIV,FLT,FNEG,FEQ,FMIN,FABS,FCVT_W_S,FCVT_S_W.
// - `OPCODE_M f4=0000: load: rd,rs1, wr=1, rd_en=1, mux LSU_OUT, imm=sext(i[28:14]).
//   f4=0001: store: rs1,rs2, wr_en=1, imm=sext({i[28:19],i[4:0]}).
// - `OPCODE_UP: LUI: rd, wr=1, mux IMMEDIATE, imm={i[28:9],12'b0}.
// - Any unlisted opcode/funct: out_illegal=1, all defaults; entry still pushed; illegal_count += 1 (saturating).
// - Instruction accepted from a warp with warp_halted=1: consumed (in_ready rules apply), not pushed, not counted.
// - warp_restart[w] clears warp_halted[w] next edge; a same-edge HALT accept for w wins (flag stays 1).
// - decode_count increments on every push (including halt and illegal entries), wraps modulo 2^CNT_WIDTH.
// - Reset asserted mid-operation discards all queued entries immediately; no partial outputs.
// TESTING
// - R ADD rd=3,rs1=1,rs2=2, warp 1, out_ready=1 -> next cycle out_valid=1, ADD, rd=3, rs1=1, rs2=2, wr=1, warp_id=1.
// - I ADDI imm=14'h3FFF -> out_immediate=32'hFFFF_FFFF; LUI i[28:9]=20'h12345 -> 32'h1234_5000.
// - out_ready=0, push 2 instrs (DEPTH=2) -> in_ready=0, third held; release -> 3 entries out in order.
// - HALT warp 2, then ADD warp 2 -> one halt entry, ADD dropped, warp_halted=4'b0100; restart[2] -> next ADD decoded.
// - R funct4=0101 and unknown opcode -> out_illegal=1 both, illegal_count=2, decode_count=2.
// - Reset low with 2 entries queued -> out_valid=0, counters=0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/warp_instr_decoder.sv
// Multi-warp instruction decoder: decodes one (instruction, warp) per cycle
// into a control bundle, queues bundles in a small FIFO toward issue, and
// tracks per-warp halt state plus decode/illegal statistics.
module warp_instr_decoder #(
  parameter int unsigned NUM_WARPS  = 4,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned IS_SCALAR  = 0,
  localparam int unsigned WID_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instruction,
  input  logic [WID_W-1:0]     in_warp_id,
  input  logic [NUM_WARPS-1:0] warp_restart,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WID_W-1:0]     out_warp_id,
  output logic                 out_reg_write_enable,
  output logic                 out_mem_write_enable,
  output logic                 out_mem_read_enable,
  output logic                 out_branch,
  output logic                 out_halt,
  output logic                 out_illegal,
  output logic                 out_scalar_instruction,
  output logic [1:0]           out_reg_input_mux,
  output logic [31:0]          out_immediate,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [4:0]           out_alu_instruction,
  output logic [NUM_WARPS-1:0] warp_halted,
  output logic [CNT_WIDTH-1:0] decode_count,
  output logic [CNT_WIDTH-1:0] illegal_count
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned ALU_W  = 5;
  localparam int unsigned MUX_W  = 2;
  localparam int unsigned OPC_W  = 3;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [OPC_W-1:0] OPC_R    = 3'd0;
  localparam logic [OPC_W-1:0] OPC_I    = 3'd1;
  localparam logic [OPC_W-1:0] OPC_F    = 3'd2;
  localparam logic [OPC_W-1:0] OPC_M    = 3'd3;
  localparam logic [OPC_W-1:0] OPC_J    = 3'd4;
  localparam logic [OPC_W-1:0] OPC_UP   = 3'd5;
  localparam logic [OPC_W-1:0] OPC_HALT = 3'd7;

  typedef enum logic [MUX_W-1:0] {
    MUX_ALU_OUT   = 2'd0,
    MUX_LSU_OUT   = 2'd1,
    MUX_IMMEDIATE = 2'd2
  } reg_input_mux_t;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_MUL = 5'd2, ALU_DIV = 5'd3,
    ALU_SLT = 5'd4, ALU_SEQ = 5'd5, ALU_SNEZ = 5'd6, ALU_MIN = 5'd7,
    ALU_ABS = 5'd8, ALU_ADDI = 5'd9, ALU_MULI = 5'd10, ALU_DIVI = 5'd11,
    ALU_SLLI = 5'd12, ALU_FADD = 5'd13, ALU_FSUB = 5'd14, ALU_FMUL = 5'd15,
    ALU_FDIV = 5'd16, ALU_FLT = 5'd17, ALU_FNEG = 5'd18, ALU_FEQ = 5'd19,
    ALU_FMIN = 5'd20, ALU_FABS = 5'd21, ALU_FCVT_W_S = 5'd22,
    ALU_FCVT_S_W = 5'd23, ALU_JAL = 5'd24, ALU_BEQ = 5'd25
  } alu_instruction_t;

  typedef struct packed {
    logic [WID_W-1:0] warp_id;
    logic             reg_we;
    logic             mem_we;
    logic             mem_re;
    logic             branch;
    logic             halt;
    logic             illegal;
    logic             scalar;
    reg_input_mux_t   mux;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    alu_instruction_t alu;
  } entry_t;

  // Idle/default bundle: everything zero except mux and ALU op.
  function automatic entry_t entry_default();
    entry_t e;
    e     = '0;
    e.mux = MUX_ALU_OUT;
    e.alu = ALU_ADDI;
    return e;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [OPC_W-1:0] opc_c;
  logic [2:0]       f3_c;
  logic [3:0]       f4_c;
  entry_t           dec_c;
  logic             bad_c;
  logic             halted_hit_c;
  logic             accept_c, push_c, pop_c;

  logic [OCC_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [NUM_WARPS-1:0] warp_halted_q, warp_halted_d;
  logic [CNT_WIDTH-1:0] decode_cnt_q, decode_cnt_d, illegal_cnt_q, illegal_cnt_d;
  entry_t               fifo_q [FIFO_DEPTH];
  entry_t               head_c;

  assign opc_c = in_instruction[31:29];
  assign f3_c  = in_instruction[14:12];
  assign f4_c  = in_instruction[13:10];

  // Decode the offered instruction into a bundle; illegal encodings collapse to defaults.
  always_comb begin
    dec_c         = entry_default();
    dec_c.warp_id = in_warp_id;
    bad_c         = 1'b0;
    case (opc_c)
      OPC_HALT: dec_c.halt = 1'b1;
      OPC_J: begin
        if (f3_c == 3'b000) begin
          dec_c.alu = ALU_JAL;
          dec_c.imm = DATA_W'($signed({in_instruction[28:13], in_instruction[9:0], 2'b00}));
        end else if (f3_c == 3'b001) begin
          dec_c.alu    = ALU_BEQ;
          dec_c.branch = 1'b1;
          dec_c.rs1    = in_instruction[9:5];
          dec_c.rs2    = in_instruction[18:14];
          dec_c.imm    = DATA_W'($signed({in_instruction[28:19], in_instruction[13],
                                          in_instruction[4:0], 2'b00}));
        end else begin
          bad_c = 1'b1;
        end
      end
      OPC_R: begin
        dec_c.rd     = in_instruction[4:0];
        dec_c.rs1    = in_instruction[9:5];
        dec_c.rs2    = in_instruction[18:14];
        dec_c.reg_we = 1'b1;
        case (f4_c)
          4'b0000: dec_c.alu = ALU_ADD;
          4'b0001: dec_c.alu = ALU_SUB;
          4'b0010: dec_c.alu = ALU_MUL;
          4'b0011: dec_c.alu = ALU_DIV;
          4'b0100: dec_c.alu = ALU_SLT;
          4'b0110: dec_c.alu = ALU_SEQ;
          4'b0111: dec_c.alu = ALU_SNEZ;
          4'b1000: dec_c.alu = ALU_MIN;
          4'b1001: dec_c.alu = ALU_ABS;
          default: bad_c = 1'b1;
        endcase
      end
      OPC_I: begin
        dec_c.rd     = in_instruction[4:0];
        dec_c.rs1    = in_instruction[9:5];
        dec_c.reg_we = 1'b1;
        dec_c.imm    = DATA_W'($signed(in_instruction[27:14]));
        case (f4_c)
          4'b0000: dec_c.alu = ALU_ADDI;
          4'b0010: dec_c.alu = ALU_MULI;
          4'b0011: dec_c.alu = ALU_DIVI;
          4'b1010: dec_c.alu = ALU_SLLI;
          default: bad_c = 1'b1;
        endcase
      end
      OPC_F: begin
        dec_c.rd     = in_instruction[4:0];
        dec_c.rs1    = in_instruction[9:5];
        dec_c.reg_we = 1'b1;
        // FP ops are numbered contiguously from FADD in funct4 order.
        if (f4_c <= 4'd10) dec_c.alu = alu_instruction_t'(ALU_W'(ALU_FADD) + ALU_W'(f4_c));
        else bad_c = 1'b1;
      end
      OPC_M: begin
        case (f4_c)
          4'b0000: begin
            dec_c.rd     = in_instruction[4:0];
            dec_c.rs1    = in_instruction[9:5];
            dec_c.reg_we = 1'b1;
            dec_c.mem_re = 1'b1;
            dec_c.mux    = MUX_LSU_OUT;
            dec_c.imm    = DATA_W'($signed(in_instruction[28:14]));
          end
          4'b0001: begin
            dec_c.rs1    = in_instruction[9:5];
            dec_c.rs2    = in_instruction[18:14];
            dec_c.mem_we = 1'b1;
            dec_c.imm    = DATA_W'($signed({in_instruction[28:19], in_instruction[4:0]}));
          end
          default: bad_c = 1'b1;
        endcase
      end
      OPC_UP: begin
        dec_c.rd     = in_instruction[4:0];
        dec_c.reg_we = 1'b1;
        dec_c.mux    = MUX_IMMEDIATE;
        dec_c.imm    = {in_instruction[28:9], 12'b0};
      end
      default: bad_c = 1'b1;
    endcase
    if (bad_c) begin
      dec_c         = entry_default();
      dec_c.warp_id = in_warp_id;
      dec_c.illegal = 1'b1;
    end
    dec_c.scalar = (IS_SCALAR != 0) && !dec_c.halt;
  end

  // Look up the halted flag of the issuing warp (out-of-range ids read as running).
  always_comb begin
    halted_hit_c = 1'b0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      if (in_warp_id == WID_W'(w)) halted_hit_c = warp_halted_q[w];
    end
  end

  assign in_ready  = (count_q < OCC_W'(FIFO_DEPTH));
  assign out_valid = (count_q != '0);
  assign accept_c  = in_valid && in_ready;
  assign push_c    = accept_c && !halted_hit_c;
  assign pop_c     = out_valid && out_ready;

  // Next-state for FIFO bookkeeping, halt flags and statistics counters.
  always_comb begin
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    decode_cnt_d  = decode_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    warp_halted_d = warp_halted_q & ~warp_restart;
    if (push_c && !pop_c)      count_d = count_q + OCC_W'(1);
    else if (!push_c && pop_c) count_d = count_q - OCC_W'(1);
    if (push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_c)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push_c) begin
      decode_cnt_d = decode_cnt_q + CNT_WIDTH'(1);
      if (dec_c.illegal && (illegal_cnt_q != '1)) illegal_cnt_d = illegal_cnt_q + CNT_WIDTH'(1);
    end
    // A HALT accepted this edge beats a same-edge restart of that warp.
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      if (push_c && dec_c.halt && (in_warp_id == WID_W'(w))) warp_halted_d[w] = 1'b1;
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      warp_halted_q <= '0;
      decode_cnt_q  <= '0;
      illegal_cnt_q <= '0;
    end else begin
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      warp_halted_q <= warp_halted_d;
      decode_cnt_q  <= decode_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // Bundle storage; validity is carried by count_q, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wr_ptr_q] <= dec_c;
  end

  // Head entry, forced to the idle bundle while the buffer is empty.
  always_comb begin
    head_c = entry_default();
    if (out_valid) head_c = fifo_q[rd_ptr_q];
  end

  assign out_warp_id            = head_c.warp_id;
  assign out_reg_write_enable   = head_c.reg_we;
  assign out_mem_write_enable   = head_c.mem_we;
  assign out_mem_read_enable    = head_c.mem_re;
  assign out_branch             = head_c.branch;
  assign out_halt               = head_c.halt;
  assign out_illegal            = head_c.illegal;
  assign out_scalar_instruction = head_c.scalar;
  assign out_reg_input_mux      = head_c.mux;
  assign out_immediate          = head_c.imm;
  assign out_rd                 = head_c.rd;
  assign out_rs1                = head_c.rs1;
  assign out_rs2                = head_c.rs2;
  assign out_alu_instruction    = head_c.alu;
  assign warp_halted            = warp_halted_q;
  assign decode_count           = decode_cnt_q;
  assign illegal_count          = illegal_cnt_q;

endmodule

// File: tb/tb_warp_instr_decoder.sv
// Scoreboard bench for warp_instr_decoder: directed scenarios plus random traffic
// checked against a rule-level decode model.
module tb_warp_instr_decoder;

  localparam int OP_R = 0, OP_I = 1, OP_F = 2, OP_M = 3, OP_J = 4, OP_UP = 5, OP_HALT = 7;
  localparam int A_ADD = 0, A_SUB = 1, A_MUL = 2, A_DIV = 3, A_SLT = 4, A_SEQ = 5, A_SNEZ = 6;
  localparam int A_MIN = 7, A_ABS = 8, A_ADDI = 9, A_MULI = 10, A_DIVI = 11, A_SLLI = 12;
  localparam int A_FADD = 13, A_JAL = 24, A_BEQ = 25;
  localparam int M_ALU = 0, M_LSU = 1, M_IMM = 2;

  typedef struct packed {
    logic [1:0]  wid;
    logic        we, mwe, mre, br, halt, ill, scalar;
    logic [1:0]  mux;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2, alu;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instruction = '0;
  logic [1:0]  in_warp_id = '0;
  logic [3:0]  warp_restart = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_warp_id;
  logic        out_reg_write_enable, out_mem_write_enable, out_mem_read_enable;
  logic        out_branch, out_halt, out_illegal, out_scalar_instruction;
  logic [1:0]  out_reg_input_mux;
  logic [31:0] out_immediate;
  logic [4:0]  out_rd, out_rs1, out_rs2, out_alu_instruction;
  logic [3:0]  warp_halted;
  logic [15:0] decode_count, illegal_count;

  warp_instr_decoder dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction),
    .in_warp_id(in_warp_id), .warp_restart(warp_restart),
    .out_valid(out_valid), .out_ready(out_ready), .out_warp_id(out_warp_id),
    .out_reg_write_enable(out_reg_write_enable), .out_mem_write_enable(out_mem_write_enable),
    .out_mem_read_enable(out_mem_read_enable), .out_branch(out_branch), .out_halt(out_halt),
    .out_illegal(out_illegal), .out_scalar_instruction(out_scalar_instruction),
    .out_reg_input_mux(out_reg_input_mux), .out_immediate(out_immediate),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_alu_instruction(out_alu_instruction), .warp_halted(warp_halted),
    .decode_count(decode_count), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t exp_q[$];
  logic [3:0]  m_halted = '0;
  logic [15:0] m_dec = '0;
  logic [15:0] m_ill = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int n);
    logic signed [31:0] s;
    s = $signed(v << (32 - n));
    return 32'(s >>> (32 - n));
  endfunction

  function automatic int r_alu(input int f4);
    case (f4)
      0: return A_ADD;  1: return A_SUB;  2: return A_MUL;  3: return A_DIV;
      4: return A_SLT;  6: return A_SEQ;  7: return A_SNEZ; 8: return A_MIN;
      9: return A_ABS;
      default: return -1;
    endcase
  endfunction

  function automatic int i_alu(input int f4);
    case (f4)
      0: return A_ADDI; 2: return A_MULI; 3: return A_DIVI; 10: return A_SLLI;
      default: return -1;
    endcase
  endfunction

  // Reference decode built directly from the encoding rules.
  function automatic exp_t ref_decode(input logic [31:0] i, input logic [1:0] w);
    exp_t e;
    int op, f3, f4, a;
    bit ok;
    op = int'(i[31:29]); f3 = int'(i[14:12]); f4 = int'(i[13:10]);
    e = '0; e.mux = 2'(M_ALU); e.alu = 5'(A_ADDI); e.wid = w;
    ok = 1'b1;
    if (op == OP_HALT) e.halt = 1'b1;
    else if (op == OP_J && f3 == 0) begin
      e.alu = 5'(A_JAL);
      e.imm = sext((32'(i[28:13]) << 12) | (32'(i[9:0]) << 2), 28);
    end else if (op == OP_J && f3 == 1) begin
      e.alu = 5'(A_BEQ); e.br = 1'b1; e.rs1 = i[9:5]; e.rs2 = i[18:14];
      e.imm = sext((32'(i[28:19]) << 8) | (32'(i[13]) << 7) | (32'(i[4:0]) << 2), 18);
    end else if (op == OP_R) begin
      a = r_alu(f4);
      if (a < 0) ok = 1'b0;
      else begin e.alu = 5'(a); e.rd = i[4:0]; e.rs1 = i[9:5]; e.rs2 = i[18:14]; e.we = 1'b1; end
    end else if (op == OP_I) begin
      a = i_alu(f4);
      if (a < 0) ok = 1'b0;
      else begin
        e.alu = 5'(a); e.rd = i[4:0]; e.rs1 = i[9:5]; e.we = 1'b1;
        e.imm = sext(32'(i[27:14]), 14);
      end
    end else if (op == OP_F) begin
      if (f4 > 10) ok = 1'b0;
      else begin e.alu = 5'(A_FADD + f4); e.rd = i[4:0]; e.rs1 = i[9:5]; e.we = 1'b1; end
    end else if (op == OP_M && f4 == 0) begin
      e.rd = i[4:0]; e.rs1 = i[9:5]; e.we = 1'b1; e.mre = 1'b1; e.mux = 2'(M_LSU);
      e.imm = sext(32'(i[28:14]), 15);
    end else if (op == OP_M && f4 == 1) begin
      e.rs1 = i[9:5]; e.rs2 = i[18:14]; e.mwe = 1'b1;
      e.imm = sext((32'(i[28:19]) << 5) | 32'(i[4:0]), 15);
    end else if (op == OP_UP) begin
      e.rd = i[4:0]; e.we = 1'b1; e.mux = 2'(M_IMM); e.imm = 32'(i[28:9]) << 12;
    end else ok = 1'b0;
    if (!ok) begin
      e = '0; e.mux = 2'(M_ALU); e.alu = 5'(A_ADDI); e.wid = w; e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] mk_r(input int f4, input int rd, input int rs1, input int rs2);
    return (32'(rs2) << 14) | (32'(f4) << 10) | (32'(rs1) << 5) | 32'(rd);
  endfunction

  task automatic check_state();
    chk("decode_count", 64'(decode_count), 64'(m_dec));
    chk("illegal_count", 64'(illegal_count), 64'(m_ill));
    chk("warp_halted", 64'(warp_halted), 64'(m_halted));
  endtask

  // Drive one cycle of stimulus (called just after a rising edge) and advance the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [1:0] w,
                      input logic [3:0] rst_p, input logic ordy, output logic acc);
    exp_t e;
    logic [3:0] newhalt;
    in_valid = v; in_instruction = ins; in_warp_id = w; warp_restart = rst_p; out_ready = ordy;
    acc = v && in_ready;
    newhalt = '0;
    if (acc && !m_halted[w]) begin
      e = ref_decode(ins, w);
      exp_q.push_back(e);
      m_dec = m_dec + 16'd1;
      if (e.ill && m_ill != 16'hFFFF) m_ill = m_ill + 16'd1;
      if (e.halt) newhalt[w] = 1'b1;
    end
    m_halted = (m_halted & ~rst_p) | newhalt;
    @(posedge clk); #1;
    in_valid = 1'b0; warp_restart = '0;
    check_state();
  endtask

  task automatic drain();
    logic acc;
    for (int k = 0; k < 64 && exp_q.size() != 0; k++) step(1'b0, '0, '0, '0, 1'b1, acc);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every handshaked head entry must match the oldest expected bundle.
  always @(negedge clk) begin
    exp_t e;
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {out_warp_id, out_alu_instruction}, '0);
      end else begin
        e = exp_q.pop_front();
        chk("entry", 64'({out_warp_id, out_reg_write_enable, out_mem_write_enable,
                          out_mem_read_enable, out_branch, out_halt, out_illegal,
                          out_scalar_instruction, out_reg_input_mux, out_immediate,
                          out_rd, out_rs1, out_rs2, out_alu_instruction}), 64'(e));
      end
    end
  end

  initial begin
    logic acc;
    logic [31:0] ins;
    logic [31:0] add_w2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_alu", 64'(out_alu_instruction), 64'(A_ADDI));
    chk("rst_mux", 64'(out_reg_input_mux), 64'(M_ALU));
    chk("rst_imm", 64'(out_immediate), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    check_state();

    // Basic R-type decode with one-cycle latency.
    step(1'b1, mk_r(0, 3, 1, 2), 2'd1, '0, 1'b1, acc);
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_fields", 64'({out_alu_instruction, out_rd, out_rs1, out_rs2, out_reg_write_enable, out_warp_id}),
        64'({5'(A_ADD), 5'd3, 5'd1, 5'd2, 1'b1, 2'd1}));
    step(1'b1, (32'(OP_I) << 29) | (32'h3FFF << 14) | 32'd7, 2'd0, '0, 1'b1, acc);
    chk("addi_imm", 64'(out_immediate), 64'hFFFF_FFFF);
    step(1'b1, (32'(OP_UP) << 29) | (32'h12345 << 9), 2'd3, '0, 1'b1, acc);
    chk("lui_imm", 64'(out_immediate), 64'h1234_5000);
    drain();

    // Backpressure: buffer fills, third instruction waits, order preserved.
    step(1'b1, mk_r(1, 4, 5, 6), 2'd0, '0, 1'b0, acc);
    step(1'b1, mk_r(2, 7, 8, 9), 2'd1, '0, 1'b0, acc);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    ins = mk_r(3, 10, 11, 12);
    step(1'b1, ins, 2'd2, '0, 1'b0, acc);
    chk("third_held", 64'(acc), 64'd0);
    acc = 1'b0;
    for (int k = 0; k < 8 && !acc; k++) step(1'b1, ins, 2'd2, '0, 1'b1, acc);
    chk("third_accepted", 64'(acc), 64'd1);
    drain();

    // Halt handling and restart.
    add_w2 = mk_r(0, 1, 2, 3);
    step(1'b1, 32'hE000_0000, 2'd2, '0, 1'b1, acc);
    step(1'b1, add_w2, 2'd2, '0, 1'b1, acc);
    chk("halted_flags", 64'(warp_halted), 64'h4);
    step(1'b0, '0, '0, 4'b0100, 1'b1, acc);
    chk("restart_flags", 64'(warp_halted), 64'h0);
    step(1'b1, add_w2, 2'd2, '0, 1'b1, acc);
    drain();

    // Reset with two entries queued.
    step(1'b1, mk_r(4, 1, 1, 1), 2'd0, '0, 1'b0, acc);
    step(1'b1, mk_r(6, 2, 2, 2), 2'd1, '0, 1'b0, acc);
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    reset = 1'b0;
    exp_q.delete(); m_dec = '0; m_ill = '0; m_halted = '0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_counts", 64'({decode_count, illegal_count}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    // Illegal encodings.
    step(1'b1, mk_r(5, 1, 2, 3), 2'd3, '0, 1'b1, acc);
    chk("illegal_r", 64'(out_illegal), 64'd1);
    step(1'b1, 32'hC000_0000, 2'd3, '0, 1'b1, acc);
    chk("illegal_op", 64'(out_illegal), 64'd1);
    chk("illegal_totals", 64'({decode_count, illegal_count}), 64'({16'd2, 16'd2}));
    drain();

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom % 4) != 0, $urandom, 2'($urandom % 4),
           (($urandom % 8) == 0) ? 4'($urandom) : 4'd0, ($urandom % 4) != 0, acc);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
